// File: rtl/mvm_result_requant_pack.sv
`default_nettype none
// mvm_result_requant_pack: requantises MVM sums to int8, packs B lanes per word, buffers words in a FIFO.
// Optional macro MVM_REQUANT_SATCOUNT_EN builds the saturation event counter driving o_sat_count.
// Revision: 1.0
module mvm_result_requant_pack #(
  parameter int S     = 48,
  parameter int N     = 8,
  parameter int B     = 16,
  parameter int DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic signed [S-1:0] i_sum,
  input  logic                i_first,
  input  logic                i_last,
  input  logic                i_pause,
  input  logic [5:0]          i_shift,
  output logic [B*N-1:0]      o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_first,
  output logic                o_last,
  output logic                o_overflow,
  output logic                o_frame_err,
  output logic [15:0]         o_sat_count
);

  localparam int LW = $clog2(B);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = B*N + 2;
  localparam logic signed [S:0] SAT_MAX = (S+1)'((2**(N-1)) - 1);
  localparam logic signed [S:0] SAT_MIN = -SAT_MAX - (S+1)'(1);

  // Input stage: frame tracking and requantisation
  logic          active;
  logic [5:0]    shift_q;
  logic [LW-1:0] lane_cnt;
  logic          accept;
  logic [5:0]    eff_shift;
  logic [LW-1:0] idx;
  logic          done;
  logic signed [S:0] sum_ext, rnd, rounded, shifted;
  logic [N-1:0]  q;

  always_comb begin
    accept    = !i_pause && (i_first || active);
    eff_shift = i_first ? i_shift : shift_q;
    idx       = i_first ? '0 : lane_cnt;
    done      = (idx == LW'(B-1)) || i_last;
    sum_ext   = {i_sum[S-1], i_sum};
    rnd       = '0;
    // No rounding bias once the shift swallows the whole sum: result is pure sign fill
    if (eff_shift != 6'd0 && int'(eff_shift) < S)
      rnd = (S+1)'(1) <<< (eff_shift - 6'd1);
    rounded   = sum_ext + rnd;
    shifted   = rounded >>> eff_shift;
    q         = shifted[N-1:0];
    if (shifted > SAT_MAX)
      q = SAT_MAX[N-1:0];
    else if (shifted < SAT_MIN)
      q = SAT_MIN[N-1:0];
  end

  logic          s1_valid;
  logic [N-1:0]  s1_lane;
  logic [LW-1:0] s1_idx;
  logic          s1_first;
  logic          s1_last;
  logic          s1_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active      <= 1'b0;
      shift_q     <= '0;
      lane_cnt    <= '0;
      o_frame_err <= 1'b0;
      s1_valid    <= 1'b0;
      s1_lane     <= '0;
      s1_idx      <= '0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_done     <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        active   <= !i_last;
        shift_q  <= eff_shift;
        lane_cnt <= done ? '0 : idx + LW'(1);
        if (i_first && active)
          o_frame_err <= 1'b1;
        s1_lane  <= q;
        s1_idx   <= idx;
        s1_first <= i_first;
        s1_last  <= i_last;
        s1_done  <= done;
      end
    end
  end

  // Packing stage: lane 0 of a word clears the accumulator, which also drops a discarded partial word
  logic [B*N-1:0] acc_data;
  logic           acc_first;
  logic [B*N-1:0] word;
  logic           word_first;
  logic           wr;

  always_comb begin
    word       = (s1_idx == '0) ? '0 : acc_data;
    word_first = (s1_idx == '0) ? s1_first : acc_first;
    for (int j = 0; j < B; j++)
      if (s1_idx == LW'(j))
        word[j*N +: N] = s1_lane;
    wr = s1_valid && s1_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_data  <= '0;
      acc_first <= 1'b0;
    end else if (s1_valid) begin
      acc_data  <= word;
      acc_first <= word_first;
    end
  end

  // Output FIFO; the registered head counts toward DEPTH
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          pop, load, full, push;

  always_comb begin
    pop  = o_valid && i_ready;
    load = (mem_cnt != '0) && (!o_valid || i_ready);
    full = (mem_cnt + (AW+1)'(o_valid)) == (AW+1)'(DEPTH);
    push = wr && (!full || pop);
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= {word_first, s1_last, word};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_cnt    <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (load)
        rd_ptr <= rd_ptr + AW'(1);
      mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(load);
      if (wr && full && !pop)
        o_overflow <= 1'b1;
      if (load) begin
        {o_first, o_last, o_data} <= mem[rd_ptr];
        o_valid <= 1'b1;
      end else if (pop) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef MVM_REQUANT_SATCOUNT_EN
  logic        sat_hit;
  logic [15:0] sat_cnt;

  assign sat_hit = accept && ((shifted > SAT_MAX) || (shifted < SAT_MIN));

  always_ff @(posedge i_clk) begin
    if (i_reset)
      sat_cnt <= '0;
    else if (sat_hit && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end

  assign o_sat_count = sat_cnt;
`else
  assign o_sat_count = 16'd0;
`endif

endmodule
`default_nettype wire
